// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
//   Bundles the fetch unit's bus-level signals: the redirect input from the
//   next-PC logic, the instruction-memory request/response channels and the
//   decode-side instruction channel.
//   modport master : the fetch unit side (drives requests and instructions)
//   modport slave  : the environment side (memory, next-PC logic, decode)
// Signals:
//   redirect_valid / redirect_pc            taken branch/jump and its target
//   imem_req_valid / _ready / _addr         fetch request, valid/ready
//   imem_rsp_valid / _data                  in-order fetch response, no ready
//   instr_valid / _ready / _data / _pc      buffer head towards decode
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    output imem_req_valid, imem_req_addr,
    output instr_valid, instr_data, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    input  imem_req_valid, imem_req_addr,
    input  instr_valid, instr_data, instr_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Holds the architectural PC, issues in-order fetch requests to instruction
//   memory, buffers returned words with their PCs and presents them to decode.
//   A redirect reloads the PC, clears the buffer and discards every response
//   still outstanding for the wrong path (FLUSH state).
// Parameters:
//   RESET_PC   PC loaded on reset
//   BUF_DEPTH  buffer entries; also the cap on (in-flight + buffered) words
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    instr_fetch_unit_if.master (redirect, imem req/rsp, instr channel)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instr_fetch_unit_if.master        bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      exp_pc_q, exp_pc_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] stale_q, stale_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      buf_data_q [BUF_DEPTH];
  logic [31:0]      buf_data_d [BUF_DEPTH];
  logic [31:0]      buf_pc_q   [BUF_DEPTH];
  logic [31:0]      buf_pc_d   [BUF_DEPTH];

  logic        credit_ok_s;
  logic        req_valid_s;
  logic        req_fire_s;
  logic        push_s;
  logic        pop_s;
  logic        stale_rsp_s;
  logic [31:0] target_s;

  // Circular-buffer pointer advance (BUF_DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return PTR_ZERO;
    end else begin
      return p + PTR_ONE;
    end
  endfunction

  // Handshake qualifiers and request gating.
  always_comb begin
    // Buffer space is reserved at request time so every response has a slot.
    credit_ok_s = (({1'b0, inflight_q} + {1'b0, occ_q}) < DEPTH_EXT);
    // rst_n gating keeps the request quiet while reset is asserted.
    req_valid_s = rst_n && (state_q == ST_FETCH) && !bus.redirect_valid && credit_ok_s;
    req_fire_s  = req_valid_s && bus.imem_req_ready;
    stale_rsp_s = bus.imem_rsp_valid && (stale_q != CNT_ZERO);
    push_s      = bus.imem_rsp_valid && (stale_q == CNT_ZERO) &&
                  (state_q == ST_FETCH) && !bus.redirect_valid;
    pop_s       = (occ_q != CNT_ZERO) && bus.instr_ready;
    target_s    = bus.redirect_pc & 32'hFFFF_FFFC;
  end

  // Next-state logic: PC, counters, buffer and FETCH/FLUSH control.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    exp_pc_d   = exp_pc_q;
    inflight_d = inflight_q;
    stale_d    = stale_q;
    occ_d      = occ_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;

    // Every response retires one in-flight request, pushed or dropped.
    case ({req_fire_s, bus.imem_rsp_valid})
      2'b10:   inflight_d = inflight_q + CNT_ONE;
      2'b01:   inflight_d = inflight_q - CNT_ONE;
      default: inflight_d = inflight_q;
    endcase

    if (bus.redirect_valid) begin
      // No request fires this cycle, so whatever is still outstanding after
      // this cycle's response is wrong-path and must be discarded.
      pc_d     = target_s;
      exp_pc_d = target_s;
      occ_d    = CNT_ZERO;
      rd_ptr_d = PTR_ZERO;
      wr_ptr_d = PTR_ZERO;
      stale_d  = inflight_d;
      if (inflight_d != CNT_ZERO) begin
        state_d = ST_FLUSH;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      if (req_fire_s) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end

      if (push_s) begin
        buf_data_d[wr_ptr_q] = bus.imem_rsp_data;
        buf_pc_d[wr_ptr_q]   = exp_pc_q;
        wr_ptr_d             = ptr_inc(wr_ptr_q);
        exp_pc_d             = exp_pc_q + 32'd4;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + CNT_ONE;
        2'b01:   occ_d = occ_q - CNT_ONE;
        default: occ_d = occ_q;
      endcase

      if (stale_rsp_s) begin
        stale_d = stale_q - CNT_ONE;
        if (stale_q == CNT_ONE) begin
          state_d = ST_FETCH;
        end else begin
          state_d = state_q;
        end
      end else begin
        stale_d = stale_q;
      end
    end
  end

  // State and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      exp_pc_q   <= RESET_PC;
      inflight_q <= CNT_ZERO;
      stale_q    <= CNT_ZERO;
      occ_q      <= CNT_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      wr_ptr_q   <= PTR_ZERO;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data_q[i] <= 32'd0;
        buf_pc_q[i]   <= 32'd0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      exp_pc_q   <= exp_pc_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      buf_data_q <= buf_data_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

  // Output drive: request address is the PC, decode sees the buffer head.
  always_comb begin
    bus.imem_req_valid = req_valid_s;
    bus.imem_req_addr  = pc_q;
    bus.instr_valid    = (occ_q != CNT_ZERO);
    bus.instr_data     = buf_data_q[rd_ptr_q];
    bus.instr_pc       = buf_pc_q[rd_ptr_q];
  end

endmodule
